// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 daisy-chain driver: register map, word
// layout, FSM state codes and frame timing helper.
package max7219_pkg;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned ROWS      = 8;
  localparam logic [2:0]  STEP_INTEN = 3'd4;
  localparam logic [2:0]  STEP_LAST  = 3'd5;

  // One 16-bit word as clocked into a single MAX7219
  typedef struct packed {
    logic [3:0] pad;
    logic [3:0] addr;
    logic [7:0] data;
  } mx_word_t;

  typedef enum logic [5:0] {
    ST_STARTUP      = 6'h00,
    ST_INIT_LOAD    = 6'h01,
    ST_FRAME_BEGIN  = 6'h02,
    ST_FRAME_SHIFT  = 6'h03,
    ST_FRAME_END    = 6'h04,
    ST_FRAME_LATCH  = 6'h05,
    ST_REFRESH_LOAD = 6'h06,
    ST_IDLE         = 6'h07
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE, PH_BEGIN, PH_SHIFT, PH_END, PH_LATCH
  } tx_phase_t;

  typedef enum logic [1:0] {
    MODE_INIT, MODE_REFRESH, MODE_INTENSITY
  } mode_t;

  // Ticks needed for one frame across n chained devices
  function automatic int unsigned frame_ticks(input int unsigned n);
    return 32'd3 + 32'd32 * n;
  endfunction

endpackage

// File: rtl/max7219_frame_tx.sv
// Tick generator and frame serialiser: shifts NUM_DEVICES 16-bit words MSB
// first between a CS fall and CS rise, two ticks per bit.
module max7219_frame_tx
  import max7219_pkg::*;
#(
  parameter int unsigned NUM_DEVICES = 4,
  parameter int unsigned CLK_DIV     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic [NUM_DEVICES*16-1:0]   i_frame,
  output logic                        o_tick_c,
  output logic                        o_done,
  output tx_phase_t                   o_phase,
  output logic                        o_din,
  output logic                        o_cs,
  output logic                        o_clk
);

  localparam int unsigned FRAME_W = NUM_DEVICES * WORD_W;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  logic [DIV_W-1:0]   r_div;
  logic [FRAME_W-1:0] r_shreg;
  logic [BIT_W-1:0]   r_bit;
  logic               r_half;

  assign o_tick_c = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (o_tick_c) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Start arms the serialiser; every pin change then happens on a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_phase <= PH_IDLE;
      o_done  <= 1'b0;
      o_din   <= 1'b0;
      o_cs    <= 1'b1;
      o_clk   <= 1'b0;
      r_shreg <= '0;
      r_bit   <= '0;
      r_half  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        o_phase <= PH_BEGIN;
      end else if (o_tick_c) begin
        case (o_phase)
          PH_BEGIN: begin
            o_cs    <= 1'b0;
            o_clk   <= 1'b0;
            r_shreg <= i_frame;
            r_bit   <= '0;
            r_half  <= 1'b0;
            o_phase <= PH_SHIFT;
          end
          PH_SHIFT: begin
            if (!r_half) begin
              o_din  <= r_shreg[FRAME_W-1];
              o_clk  <= 1'b0;
              r_half <= 1'b1;
            end else begin
              o_clk   <= 1'b1;
              r_half  <= 1'b0;
              r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
              if (r_bit == BIT_W'(FRAME_W - 1)) begin
                o_phase <= PH_END;
              end else begin
                r_bit <= r_bit + BIT_W'(1);
              end
            end
          end
          PH_END: begin
            o_clk   <= 1'b0;
            o_phase <= PH_LATCH;
          end
          PH_LATCH: begin
            o_cs    <= 1'b1;
            o_done  <= 1'b1;
            o_phase <= PH_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/max7219_chain.sv
// MAX7219 daisy-chain driver: framebuffer, power-up sequence, refresh and
// runtime intensity requests, all serialised through max7219_frame_tx.
module max7219_chain
  import max7219_pkg::*;
#(
  parameter int unsigned NUM_DEVICES    = 4,
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned STARTUP_WAIT   = 20,
  parameter logic [3:0]  INIT_INTENSITY = 4'h0,
  parameter logic [7:0]  DECODE_MODE    = 8'h00,
  parameter logic [2:0]  SCAN_LIMIT     = 3'd7,
  localparam int unsigned DEV_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DEV_W-1:0] wr_dev,
  input  logic [2:0]       wr_row,
  input  logic [7:0]       wr_data,
  input  logic             refresh,
  input  logic             intensity_set,
  input  logic [3:0]       intensity_in,
  output logic             busy,
  output logic             init_done,
  output logic [5:0]       state_dbg,
  output logic             io_din,
  output logic             io_cs,
  output logic             io_clk
);

  localparam int unsigned FRAME_W = NUM_DEVICES * WORD_W;

  state_t             r_state;
  mode_t              r_mode;
  logic [2:0]         r_step;
  logic [15:0]        r_cnt;
  logic               r_pend_int;
  logic               r_pend_ref;
  logic [3:0]         r_intensity;
  logic [7:0]         r_fb [NUM_DEVICES][ROWS];
  logic [FRAME_W-1:0] r_frame;
  logic               r_start;
  logic               r_busy;
  logic               r_init_done;

  logic               w_tick;
  logic               w_done;
  tx_phase_t          w_phase;
  mx_word_t           w_init_word;
  logic [FRAME_W-1:0] w_frame;
  logic               w_req_int;
  logic               w_req_ref;

  assign busy      = r_busy;
  assign init_done = r_init_done;
  assign state_dbg = r_state;
  assign w_req_int = r_pend_int | intensity_set;
  assign w_req_ref = r_pend_ref | refresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NUM_DEVICES; d++) begin
        for (int r = 0; r < ROWS; r++) begin
          r_fb[d][r] <= '0;
        end
      end
    end else if (wr_en && (32'(wr_dev) < NUM_DEVICES)) begin
      r_fb[wr_dev][wr_row] <= wr_data;
    end
  end

  always_comb begin
    w_init_word = '0;
    case (r_step)
      3'd0:    w_init_word = '{pad: 4'h0, addr: REG_SHUTDOWN,  data: 8'h00};
      3'd1:    w_init_word = '{pad: 4'h0, addr: REG_TEST,      data: 8'h00};
      3'd2:    w_init_word = '{pad: 4'h0, addr: REG_DECODE,    data: DECODE_MODE};
      3'd3:    w_init_word = '{pad: 4'h0, addr: REG_SCANLIMIT, data: {5'b0, SCAN_LIMIT}};
      3'd4:    w_init_word = '{pad: 4'h0, addr: REG_INTENSITY, data: {4'b0, r_intensity}};
      3'd5:    w_init_word = '{pad: 4'h0, addr: REG_SHUTDOWN,  data: 8'h01};
      default: w_init_word = '0;
    endcase
  end

  // Device d occupies bits [d*16 +: 16], so the far device is shifted first
  always_comb begin
    w_frame = '0;
    for (int d = 0; d < NUM_DEVICES; d++) begin
      if (r_state == ST_REFRESH_LOAD) begin
        w_frame[d*WORD_W +: WORD_W] = {4'h0, REG_DIGIT0 + 4'(r_step), r_fb[d][r_step]};
      end else begin
        w_frame[d*WORD_W +: WORD_W] = w_init_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_STARTUP;
      r_mode      <= MODE_INIT;
      r_step      <= '0;
      r_cnt       <= '0;
      r_pend_int  <= 1'b0;
      r_pend_ref  <= 1'b0;
      r_intensity <= INIT_INTENSITY;
      r_frame     <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_busy  <= 1'b1;
      if (intensity_set) begin
        r_intensity <= intensity_in;
        r_pend_int  <= 1'b1;
      end
      if (refresh) begin
        r_pend_ref <= 1'b1;
      end
      case (r_state)
        ST_STARTUP: begin
          if (w_tick) begin
            if (32'(r_cnt) + 32'd1 >= STARTUP_WAIT) begin
              r_cnt   <= '0;
              r_mode  <= MODE_INIT;
              r_step  <= '0;
              r_state <= ST_INIT_LOAD;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        ST_INIT_LOAD, ST_REFRESH_LOAD: begin
          if (w_tick) begin
            r_frame <= w_frame;
            r_start <= 1'b1;
            r_state <= ST_FRAME_BEGIN;
          end
        end
        ST_FRAME_BEGIN, ST_FRAME_SHIFT, ST_FRAME_END, ST_FRAME_LATCH: begin
          if (w_done) begin
            case (r_mode)
              MODE_INIT: begin
                if (r_step == STEP_LAST) begin
                  r_mode  <= MODE_REFRESH;
                  r_step  <= '0;
                  r_state <= ST_REFRESH_LOAD;
                end else begin
                  r_step  <= r_step + 3'd1;
                  r_state <= ST_INIT_LOAD;
                end
              end
              MODE_REFRESH: begin
                if (r_step == 3'd7) begin
                  r_init_done <= 1'b1;
                  r_state     <= ST_IDLE;
                  r_busy      <= w_req_int | w_req_ref;
                end else begin
                  r_step  <= r_step + 3'd1;
                  r_state <= ST_REFRESH_LOAD;
                end
              end
              default: begin
                r_state <= ST_IDLE;
                r_busy  <= w_req_int | w_req_ref;
              end
            endcase
          end else begin
            // Mirror the serialiser phase for the debug LEDs
            case (w_phase)
              PH_BEGIN: r_state <= ST_FRAME_BEGIN;
              PH_SHIFT: r_state <= ST_FRAME_SHIFT;
              PH_END:   r_state <= ST_FRAME_END;
              PH_LATCH: r_state <= ST_FRAME_LATCH;
              default:  ;
            endcase
          end
        end
        ST_IDLE: begin
          if (w_req_int) begin
            r_pend_int <= 1'b0;
            r_mode     <= MODE_INTENSITY;
            r_step     <= STEP_INTEN;
            r_state    <= ST_INIT_LOAD;
          end else if (w_req_ref) begin
            r_pend_ref <= 1'b0;
            r_mode     <= MODE_REFRESH;
            r_step     <= '0;
            r_state    <= ST_REFRESH_LOAD;
          end else begin
            r_busy <= 1'b0;
          end
        end
        default: r_state <= ST_STARTUP;
      endcase
    end
  end

  max7219_frame_tx #(
    .NUM_DEVICES (NUM_DEVICES),
    .CLK_DIV     (CLK_DIV)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (r_start),
    .i_frame  (r_frame),
    .o_tick_c (w_tick),
    .o_done   (w_done),
    .o_phase  (w_phase),
    .o_din    (io_din),
    .o_cs     (io_cs),
    .o_clk    (io_clk)
  );

endmodule
